// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shifter: op codes, controller states
// and the default datapath width.
package shift_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_stage.sv
// One power-of-two shift stage, time-multiplexed by the sequencer: shifts or
// rotates data by the distance picked by the one-hot dist_sel when en is set.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [CNT_W-1:0] dist_sel,
    input  logic             en,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] res
);

    logic [WIDTH-1:0] cand [CNT_W];

    // Every distance is a constant here, so each candidate is pure wiring.
    generate
        for (genvar gi = 0; gi < CNT_W; gi++) begin : g_dist
            localparam int D = 1 << gi;
            assign cand[gi] = (op == OP_ROL) ? ((data << D) | (data >> (WIDTH - D))) :
                              (op == OP_SLL) ?  (data << D) :
                              (op == OP_ROR) ? ((data >> D) | (data << (WIDTH - D))) :
                                                (data >> D);
        end
    endgenerate

    always_comb begin
        res = data;
        if (en) begin
            res = '0;
            for (int i = 0; i < CNT_W; i++) begin
                if (dist_sel[i]) begin
                    res = res | cand[i];
                end
            end
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: applies the log2(WIDTH) power-of-two stages
// MSB-first, one per clock, and hands the result out over valid/ack.
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [CNT_W-1:0] cnt,
    input  logic [1:0]       op,
    output logic             ready,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    input  logic             ack
);

    localparam int STG_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(CNT_W - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] stage_res;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       op_reg;
    logic [STG_W-1:0] stage_reg;
    logic [CNT_W-1:0] dist_sel;
    logic             accept;
    logic             last_stage;

    assign accept     = (state_reg == IDLE) && start;
    assign last_stage = (stage_reg == '0);
    assign dist_sel   = CNT_W'(1) << stage_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A stage runs every cycle even when its cnt bit is clear, so latency is fixed.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)      state_next = SHIFT;
            SHIFT:   if (last_stage) state_next = DONE;
            DONE:    if (ack)        state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_reg == IDLE);
        valid = (state_reg == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= '0;
            cnt_reg   <= '0;
            op_reg    <= '0;
            stage_reg <= '0;
        end else if (accept) begin
            data_reg  <= in;
            cnt_reg   <= cnt;
            op_reg    <= op;
            stage_reg <= STG_LAST;
        end else if (state_reg == SHIFT) begin
            data_reg <= stage_res;
            if (!last_stage) begin
                stage_reg <= stage_reg - STG_W'(1);
            end
        end
    end

    shift_stage #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_stage (
        .data     (data_reg),
        .dist_sel (dist_sel),
        .en       (cnt_reg[stage_reg]),
        .op       (op_reg),
        .res      (stage_res)
    );

    assign out = data_reg;

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Multi-cycle sequencer for the 16-bit shifter datapath. It accepts a shift request (operand, amount, op) and walks the log2(WIDTH) power-of-two shift stages MSB-first, applying one stage per clock. It returns the result through a valid/ack handshake. It sits between the ALU issue logic and the writeback mux, and replaces the single-cycle full barrel shifter where timing or area demands it.

Parameters:
WIDTH, 16, operand width; must be a power of two.
CNT_W, 4, shift-amount width; localparam = clog2(WIDTH), not overridable.

Ports:
clk    input   1      system clock, rising edge
rst_n  input   1      asynchronous active-low reset
start  input   1      request strobe; accepted only when ready=1
in     input   WIDTH  operand, sampled on accept
cnt    input   CNT_W  shift amount 0..WIDTH-1, sampled on accept
op     input   2      00 ROL, 01 SLL, 10 ROR, 11 SRL; sampled on accept
ready  output  1      controller idle, can accept start
out    output  WIDTH  result register
valid  output  1      out holds a completed result
ack    input   1      consumer takes result; meaningful only when valid=1

Behaviour:
- Reset (async assert, sync deassert assumed upstream): state=IDLE, out=0, valid=0, ready=1, internal cnt/op/stage regs=0.
- States: IDLE, SHIFT, DONE. ready=1 only in IDLE. valid=1 only in DONE.
- IDLE: when start=1, capture in into the data register (out reflects it), capture cnt and op, set stage=CNT_W-1, and go to SHIFT. When start=0, hold.
- SHIFT: each cycle, if cnt_r[stage]=1, data <= stage_fn(data, 2^stage, op_r). Otherwise data holds. If stage==0, go to DONE. Otherwise stage decrements.
- Latency is fixed: the accept edge is E0, stage edges are E1..E4, and valid rises after E4. This holds regardless of cnt, including cnt=0.
- stage_fn: SLL shifts left with zero fill. SRL shifts right with zero fill. ROL/ROR rotate with no bit loss. There is no arithmetic-shift op.
- DONE: out and valid are held stable until ack=1. On an ack edge, go to IDLE: valid=0 and ready=1 from the next cycle. out retains the last result in IDLE until the next accept.
- start while ready=0 is ignored (not queued). ack while valid=0 is ignored.
- Simultaneous ack and start in DONE: ack is honoured and start is dropped. The requester must re-present start once ready=1.
- in/cnt/op changes after accept have no effect on the operation in flight.
- rst_n asserted mid-SHIFT or mid-DONE: abort immediately. Outputs go to reset values and no partial result is flagged valid.
- No overflow/carry output. Bits shifted out are discarded for SLL and SRL.

Decomposition:
- Package shift_pkg: op encodings (OP_ROL=2'b00, OP_SLL=2'b01, OP_ROR=2'b10, OP_SRL=2'b11), state encoding (IDLE/SHIFT/DONE), WIDTH default.
- Sub-module shift_stage: purely combinational. Inputs are data, a one-hot distance select (from stage), an enable (cnt_r[stage]) and op; output is the shifted data. One instance is time-multiplexed across all stages.
- Controller module: FSM, stage down-counter, and the data/cnt/op registers.

Test Plan:
1. SRL in=0xF0F0, cnt=8, start at E0 -> ready falls; valid=1 after E4 with out=0x00F0; ack -> ready=1 next cycle.
2. ROL in=0x8001, cnt=1 -> out=0x0003. ROR in=0x0001, cnt=4 -> out=0x1000. Both with 4-cycle latency.
3. SLL in=0x0001, cnt=15 -> out=0x8000. SLL in=0xFFFF, cnt=0 -> out=0xFFFF, with the same latency as a nonzero shift.
4. start pulsed during SHIFT with different in -> ignored, result unchanged. ack withheld for 10 cycles in DONE -> out and valid stable throughout.
5. ack=1 and start=1 in the same DONE cycle -> start dropped, IDLE next cycle. A re-issued start is accepted normally.
6. rst_n low at the 2nd SHIFT cycle -> out=0, valid=0, ready=1 immediately (asynchronous). After release, a new request completes correctly.
